terminal_bridge: RTL and testbench
==================================

// Module: terminal_bridge
//
// PURPOSE
// - Far end of the tiny16 8-bit I/O ports: adapts them to a host serial terminal (UART 8N1).
// - Display side: accepts bytes strobed by tiny16 on OUT/OUT_EN, buffers them in a FIFO and serialises them on tx.
// - Keyboard side: deserialises rx into a one-byte holding register and presents it on tiny16 IN when tiny16 strobes IN_EN.
// - Sits beside tiny16 at top level on the same clock as the CPU (clk_1mhz).
//
// PARAMETERS
// - CLKS_PER_BIT  104  clk cycles per UART bit (9600 baud at 1 MHz); must be >= 4
// - FIFO_DEPTH      4  TX FIFO entries; power of 2, >= 2
//
// PORTS
// - clk          in   1  system clock; single clock domain
// - rst          in   1  asynchronous, active-high reset
// - dsp_data     in   8  display byte from tiny16 OUT
// - dsp_valid    in   1  one-cycle strobe from tiny16 OUT_EN; dsp_data valid this cycle
// - kbd_req      in   1  one-cycle strobe from tiny16 IN_EN requesting a key byte
// - kbd_data     out  8  key byte to tiny16 IN, registered
// - key_ready    out  1  holding register contains an unread byte
// - rx           in   1  UART serial input from host; asynchronous, idle high
// - tx           out  1  UART serial output to host; idle high
// - tx_busy      out  1  TX FSM not IDLE, or FIFO not empty
// - tx_overflow  out  1  sticky: a dsp_valid byte arrived while the FIFO was full
// - rx_overrun   out  1  sticky: a byte completed while key_ready=1 and no kbd_req
// - rx_frame_err out  1  one-cycle pulse: stop bit sampled low
//
// BEHAVIOUR
// - Reset, async: tx=1, kbd_data=8'h00, key_ready=0, all flags=0, FIFO empty, both FSMs IDLE. A frame in progress is aborted; tx goes high immediately.
// - TX FIFO push:
//   - dsp_valid with FIFO not full: push dsp_data.
//   - dsp_valid with FIFO full: byte dropped, tx_overflow<=1.
//   - Pop and push in the same cycle are both legal, including when the FIFO is full.
// - TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE with FIFO non-empty: pop the byte; tx=0 (start bit) from the next cycle.
//   - Latency: dsp_valid into an empty, idle bridge -> start bit begins 2 cycles later.
//   - Each bit lasts exactly CLKS_PER_BIT cycles. Data is LSB first (8 bits), then a stop bit (tx=1).
//   - STOP -> IDLE, and back-to-back frames add no extra idle cycle.
// - RX path: rx passes through a 2-flop synchroniser before use.
// - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: a falling edge on synced rx enters START.
//   - START: resample at CLKS_PER_BIT/2. If high, treat as a glitch and return to IDLE. If low, continue.
//   - DATA: sample each bit at mid-bit (every CLKS_PER_BIT cycles), LSB first.
//   - STOP: mid-bit sample.
//     - High: the byte is complete.
//     - Low: discard the byte, pulse rx_frame_err, and return to IDLE only after rx is seen high.
// - Byte completion:
//   - key_ready=0: load the holding register, key_ready<=1.
//   - key_ready=1: drop the new byte, rx_overrun<=1.
// - kbd_req handling:
//   - key_ready=1: kbd_data<=held byte, key_ready<=0 on the next edge.
//   - key_ready=0: kbd_data<=8'h00.
//   - kbd_data holds its value until the next kbd_req.
// - kbd_req and byte completion in the same cycle:
//   - key_ready=0: kbd_data<=8'h00, and the new byte is captured with key_ready<=1.
//   - key_ready=1: the old byte goes out on kbd_data, the new byte is captured, key_ready stays 1, and there is no overrun.
// - Sticky flags clear only on rst.
//
// STRUCTURE
// - Shared package/header terminal_defs: UART FSM state encodings (IDLE/START/DATA/STOP), default CLKS_PER_BIT, KBD_EMPTY=8'h00.
// - One sub-module: sync_fifo (params WIDTH=8, DEPTH=FIFO_DEPTH; push/pop/full/empty/dout).
// - TX FSM, RX FSM, synchroniser and holding register stay inline in terminal_bridge.
//
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
// - Single byte out: dsp_valid with 8'hA5 -> tx low 2 cycles later, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high. tx_busy falls after the stop bit.
// - Overflow: 6 back-to-back dsp_valid strobes (8'h01..8'h06) -> 8'h01..8'h05 transmitted in order (one popped immediately plus 4 held), 8'h06 dropped, tx_overflow=1.
// - Key in: drive an rx frame of 8'h41 -> key_ready=1. Then kbd_req -> kbd_data=8'h41 next cycle and key_ready=0. A second kbd_req -> kbd_data=8'h00.
// - Overrun and simultaneity: two rx frames with no kbd_req -> first byte kept, rx_overrun=1. Then a frame of 8'h42 completing in the same cycle as kbd_req -> old byte delivered, 8'h42 held, key_ready=1.
// - Errors: 1-cycle low glitch on rx -> no byte and no flag. Frame of 8'h55 with stop bit low -> rx_frame_err pulses once, key_ready unchanged.
// - Reset mid-operation: assert rst during the TX DATA state and during an RX frame -> tx=1 and all outputs at reset values. After release, a fresh dsp_valid with 8'h3C transmits cleanly.

Source files
------------

// File: rtl/terminal_defs.sv
// ---------------------------------------------------------------------------
// terminal_defs
// Shared definitions for the tiny16 terminal bridge: UART FSM state
// encodings (shared by the TX and RX state machines), the default bit period
// and the value presented on the keyboard port when no key is waiting.
// ---------------------------------------------------------------------------
package terminal_defs;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // 9600 baud from the 1 MHz CPU clock
   localparam int DEFAULT_CLKS_PER_BIT = 104;

   localparam logic [7:0] KBD_EMPTY = 8'h00;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO; dout shows the oldest entry
// whenever empty is low.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers only)
//   push, din    write request and data; accepted when not full, or when a
//                pop happens in the same cycle
//   pop          read request; ignored while empty
//   full, empty  occupancy status
//   dout         head entry
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a byte if the head leaves this cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/terminal_bridge.sv
// ---------------------------------------------------------------------------
// terminal_bridge
// Connects the tiny16 8-bit OUT/IN ports to a host terminal over UART 8N1.
// Display bytes are queued in a small FIFO and serialised on tx; bytes
// received on rx land in a one-byte holding register that tiny16 reads with
// kbd_req.
// Ports:
//   clk, rst              CPU clock, asynchronous active-high reset
//   dsp_data, dsp_valid   display byte strobed from tiny16 OUT/OUT_EN
//   kbd_req               IN_EN strobe; kbd_data updates on the next edge
//   kbd_data, key_ready   key byte to tiny16 IN, unread-byte indicator
//   rx, tx                UART lines (idle high); rx is asynchronous
//   tx_busy               transmitter active or FIFO not empty
//   tx_overflow           sticky: display byte dropped on a full FIFO
//   rx_overrun            sticky: received byte dropped, key unread
//   rx_frame_err          one-cycle pulse: stop bit sampled low
// ---------------------------------------------------------------------------
module terminal_bridge
   import terminal_defs::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] dsp_data,
   input  logic       dsp_valid,
   input  logic       kbd_req,
   output logic [7:0] kbd_data,
   output logic       key_ready,
   input  logic       rx,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_overflow,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int           CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_pop;
   logic [7:0] fifo_dout;

   logic [1:0]    tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_sh;
   logic          tx_bit_end;

   logic          rx_sync_p0;
   logic          rx_sync_p1;
   logic          rx_prev_p2;
   logic [1:0]    rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_sh;
   logic          rx_err_wait;
   logic          rx_done;
   logic [7:0]    kbd_hold;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dsp_valid),
      .din   (dsp_data),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   // ---------------- transmitter ----------------
   assign tx_bit_end = (tx_cnt == BIT_LAST);
   // The next byte is taken either from IDLE or at the very end of a stop
   // bit, so consecutive frames run back to back.
   assign fifo_pop   = !fifo_empty &&
                       ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_bit_end));
   assign tx_busy    = (tx_state != ST_IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= ST_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx       <= 1'b1;
      end else begin
         case (tx_state)
            ST_IDLE: begin
               if (fifo_pop) begin
                  tx_state <= ST_START;
                  tx_cnt   <= '0;
                  tx       <= 1'b0;
               end
            end
            ST_START: begin
               if (tx_bit_end) begin
                  tx_state <= ST_DATA;
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx       <= tx_sh[0];
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_state <= ST_STOP;
                     tx       <= 1'b1;
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                     tx     <= tx_sh[0];
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (fifo_pop) begin
                     tx_state <= ST_START;
                     tx       <= 1'b0;
                  end else begin
                     tx_state <= ST_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   // Shifter keeps the next bit to send in position 0.
   always_ff @(posedge clk) begin
      if (fifo_pop)
         tx_sh <= fifo_dout;
      else if (tx_bit_end && ((tx_state == ST_START) || (tx_state == ST_DATA)))
         tx_sh <= tx_sh >> 1;
   end

   // ---------------- receiver: synchroniser ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         rx_prev_p2 <= 1'b1;
      end else begin
         rx_sync_p0 <= rx;
         rx_sync_p1 <= rx_sync_p0;
         rx_prev_p2 <= rx_sync_p1;
      end
   end

   // ---------------- receiver: framing ----------------
   assign rx_done = (rx_state == ST_STOP) && !rx_err_wait && (rx_cnt == BIT_LAST) && rx_sync_p1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state     <= ST_IDLE;
         rx_cnt       <= '0;
         rx_bit       <= '0;
         rx_err_wait  <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_frame_err <= 1'b0;
         case (rx_state)
            ST_IDLE: begin
               // Count starts at 1: the edge was already one cycle old here,
               // which puts the start-bit check at its midpoint.
               if (rx_prev_p2 && !rx_sync_p1) begin
                  rx_state <= ST_START;
                  rx_cnt   <= CW'(1);
               end
            end
            ST_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_state <= rx_sync_p1 ? ST_IDLE : ST_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_bit == 3'd7) rx_state <= ST_STOP;
                  else                rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: begin
               if (rx_err_wait) begin
                  // Broken frame: hold off until the line returns to idle.
                  if (rx_sync_p1) begin
                     rx_err_wait <= 1'b0;
                     rx_state    <= ST_IDLE;
                  end
               end else if (rx_cnt == BIT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_sync_p1) begin
                     rx_state <= ST_IDLE;
                  end else begin
                     rx_err_wait  <= 1'b1;
                     rx_frame_err <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((rx_state == ST_DATA) && (rx_cnt == BIT_LAST))
         rx_sh <= {rx_sync_p1, rx_sh[7:1]};
   end

   // ---------------- keyboard holding register ----------------
   // A read in the same cycle as a new byte frees the slot, so the new byte
   // is kept rather than counted as an overrun.
   always_ff @(posedge clk) begin
      if (rx_done && (!key_ready || kbd_req))
         kbd_hold <= rx_sh;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbd_data    <= KBD_EMPTY;
         key_ready   <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (kbd_req)
            kbd_data <= key_ready ? kbd_hold : KBD_EMPTY;
         if (rx_done) begin
            if (!key_ready)    key_ready  <= 1'b1;
            else if (!kbd_req) rx_overrun <= 1'b1;
         end else if (kbd_req && key_ready) begin
            key_ready <= 1'b0;
         end
         if (dsp_valid && fifo_full && !fifo_pop)
            tx_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_terminal_bridge.sv
module tb_terminal_bridge;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] dsp_data = 8'h00;
   logic       dsp_valid = 1'b0;
   logic       kbd_req = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] kbd_data;
   logic       key_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_overflow;
   logic       rx_overrun;
   logic       rx_frame_err;

   int checks = 0;
   int errors = 0;

   terminal_bridge #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .dsp_data     (dsp_data),
      .dsp_valid    (dsp_valid),
      .kbd_req      (kbd_req),
      .kbd_data     (kbd_data),
      .key_ready    (key_ready),
      .rx           (rx),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_overflow  (tx_overflow),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   // Reference UART receiver on the tx line: mid-bit sampling, frames queued.
   bit         mon_en = 1'b0;
   logic [7:0] mon_q[$];
   bit         mon_ok_q[$];
   logic [7:0] mon_b;
   bit         mon_ok;

   always begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
         repeat (CPB / 2) @(negedge clk);
         mon_ok = (tx === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         mon_ok = mon_ok && (tx === 1'b1);
         mon_q.push_back(mon_b);
         mon_ok_q.push_back(mon_ok);
      end
   end

   int fe_cnt = 0;
   always @(negedge clk) if (rx_frame_err === 1'b1) fe_cnt++;

   // Keyboard-side model: a read consumes the waiting key first, then an
   // arriving byte lands if the slot is free, otherwise it is lost.
   bit         m_ready = 1'b0;
   bit         m_over = 1'b0;
   logic [7:0] m_held = 8'h00;
   logic [7:0] m_kbd = 8'h00;

   task automatic model_step(input bit done, input logic [7:0] b, input bit req);
      if (req) begin
         m_kbd   = m_ready ? m_held : 8'h00;
         m_ready = 1'b0;
      end
      if (done) begin
         if (m_ready) m_over = 1'b1;
         else begin
            m_held  = b;
            m_ready = 1'b1;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [7:0] d);
      dsp_data  = d;
      dsp_valid = 1'b1;
      @(negedge clk);
      dsp_valid = 1'b0;
   endtask

   task automatic wait_mon(input int n, input int budget);
      while (mon_q.size() < n && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("mon_count", mon_q.size(), n);
   endtask

   task automatic check_mon(input string tag, input logic [7:0] exp);
      logic [7:0] b;
      bit ok;
      if (mon_q.size() > 0) begin
         b  = mon_q.pop_front();
         ok = mon_ok_q.pop_front();
         chk(tag, b, exp);
         chk({tag, "_framing"}, ok, 1);
      end
   endtask

   // Drives one rx frame (start, 8 data LSB first, stop) plus idle time.
   // kbd_req is pulsed at cycle req_at; seen is the cycle at which
   // key_ready was first observed high (-1 if never).
   task automatic send_frame(input logic [7:0] b, input bit stop, input int req_at,
                             output int seen);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      seen = -1;
      for (int c = 0; c < FRAME + 6; c++) begin
         rx      = (c < FRAME) ? bits[c / CPB] : 1'b1;
         kbd_req = (c == req_at);
         @(negedge clk);
         if (seen < 0 && key_ready === 1'b1) seen = c + 1;
      end
      kbd_req = 1'b0;
      rx      = 1'b1;
   endtask

   task automatic kbd_read(input string tag);
      kbd_req = 1'b1;
      @(negedge clk);
      kbd_req = 1'b0;
      model_step(1'b0, 8'h00, 1'b1);
      chk({tag, "_data"}, kbd_data, m_kbd);
      chk({tag, "_ready"}, key_ready, m_ready);
   endtask

   initial begin
      int seen;
      int done_c;
      int n;
      int fe0;
      logic [7:0] b;
      logic [7:0] r1;
      logic [7:0] r2;
      logic [7:0] burst_q[$];
      logic [9:0] bits;

      // reset state
      tick(3);
      chk("rst_tx", tx, 1);
      chk("rst_kbd_data", kbd_data, 8'h00);
      chk("rst_key_ready", key_ready, 0);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_tx_overflow", tx_overflow, 0);
      chk("rst_rx_overrun", rx_overrun, 0);
      chk("rst_rx_frame_err", rx_frame_err, 0);
      rst = 1'b0;
      tick(2);
      mon_en = 1'b1;

      // single byte, cycle-exact
      strobe(8'hA5);
      chk("a5_busy", tx_busy, 1);
      chk("a5_tx_still_idle", tx, 1);
      tick();
      bits = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < CPB; c++) begin
            chk($sformatf("a5_bit%0d_cyc%0d", k, c), tx, bits[k]);
            tick();
         end
      end
      chk("a5_busy_after", tx_busy, 0);
      wait_mon(1, 20);
      check_mon("a5_mon", 8'hA5);

      // overflow: six strobes back to back
      dsp_valid = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         dsp_data = 8'(i);
         tick();
      end
      dsp_valid = 1'b0;
      chk("ovf_flag", tx_overflow, 1);
      wait_mon(5, 6 * FRAME);
      for (int i = 1; i <= 5; i++) check_mon($sformatf("ovf_byte%0d", i), 8'(i));
      tick(2 * FRAME);
      chk("ovf_sixth_dropped", mon_q.size(), 0);
      chk("ovf_busy_after", tx_busy, 0);

      // random bursts that fit in FIFO plus the in-flight frame
      for (int burst = 0; burst < 3; burst++) begin
         n = $urandom_range(1, 5);
         burst_q.delete();
         dsp_valid = 1'b1;
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            burst_q.push_back(b);
            dsp_data = b;
            tick();
         end
         dsp_valid = 1'b0;
         wait_mon(n, (n + 1) * FRAME + 20);
         for (int k = 0; k < n; k++) check_mon($sformatf("burst%0d_byte%0d", burst, k), burst_q[k]);
         tick(2 * CPB);
         chk("burst_idle", tx_busy, 0);
      end
      chk("ovf_sticky", tx_overflow, 1);

      // key in
      send_frame(8'h41, 1'b1, -1, seen);
      model_step(1'b1, 8'h41, 1'b0);
      chk("k41_ready", key_ready, m_ready);
      chk("k41_kbd_unchanged", kbd_data, m_kbd);
      chk("k41_latency_window", (seen >= 9 * CPB + CPB / 2 && seen <= 9 * CPB + CPB / 2 + 4), 1);
      done_c = seen;
      kbd_read("k41_read");
      kbd_read("k41_reread");

      // random received bytes
      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, -1, seen);
         model_step(1'b1, b, 1'b0);
         chk($sformatf("rnd%0d_ready", k), key_ready, m_ready);
         kbd_read($sformatf("rnd%0d_read", k));
      end

      // overrun, then read coinciding with a completing byte
      r1 = 8'($urandom);
      r2 = ~r1;
      send_frame(r1, 1'b1, -1, seen);
      model_step(1'b1, r1, 1'b0);
      send_frame(r2, 1'b1, -1, seen);
      model_step(1'b1, r2, 1'b0);
      chk("ovr_flag", rx_overrun, m_over);
      chk("ovr_ready", key_ready, m_ready);
      send_frame(8'h42, 1'b1, done_c - 1, seen);
      model_step(1'b1, 8'h42, 1'b1);
      chk("sim_kbd_old", kbd_data, m_kbd);
      chk("sim_ready", key_ready, m_ready);
      chk("sim_overrun_sticky", rx_overrun, m_over);
      kbd_read("sim_read42");

      // glitch and framing error
      fe0 = fe_cnt;
      rx  = 1'b0;
      tick();
      rx  = 1'b1;
      tick(FRAME);
      chk("glitch_no_err", fe_cnt, fe0);
      chk("glitch_no_key", key_ready, m_ready);
      send_frame(8'h55, 1'b0, -1, seen);
      tick(2);
      chk("ferr_one_pulse", fe_cnt, fe0 + 1);
      chk("ferr_no_key", key_ready, m_ready);
      send_frame(8'h7E, 1'b1, -1, seen);
      model_step(1'b1, 8'h7E, 1'b0);
      kbd_read("ferr_recover");
      send_frame(8'h99, 1'b1, -1, seen);
      model_step(1'b1, 8'h99, 1'b0);
      chk("pre_rst_ready", key_ready, m_ready);

      // reset in the middle of a TX frame and an RX frame
      mon_en = 1'b0;
      tick(FRAME);
      strobe(8'hC3);
      tick(14);
      rx = 1'b0;
      tick(8);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_kbd_data", kbd_data, 8'h00);
      chk("mid_rst_key_ready", key_ready, 0);
      chk("mid_rst_busy", tx_busy, 0);
      chk("mid_rst_overflow", tx_overflow, 0);
      chk("mid_rst_overrun", rx_overrun, 0);
      chk("mid_rst_frame_err", rx_frame_err, 0);
      rx = 1'b1;
      tick(3);
      rst = 1'b0;
      m_ready = 1'b0;
      m_over  = 1'b0;
      m_kbd   = 8'h00;
      tick(FRAME + 10);
      mon_q.delete();
      mon_ok_q.delete();
      mon_en = 1'b1;
      strobe(8'h3C);
      wait_mon(1, FRAME + 20);
      check_mon("post_rst_3c", 8'h3C);
      tick(CPB);
      chk("post_rst_busy", tx_busy, 0);
      chk("post_rst_key_ready", key_ready, m_ready);
      chk("post_rst_overflow", tx_overflow, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
